// File: rtl/tl_inflight_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tl_inflight_tracker                                                         |
// | Passive TileLink-UL A/D checker: per-source outstanding table, burst        |
// | tracking, response pairing, liveness watchdog, sticky error flags.          |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tl_inflight_tracker #(
    parameter int SRC_W           = 2,
    parameter int ADDR_W          = 15,
    parameter int BEAT_BYTES_LOG2 = 2,
    parameter int TIMEOUT         = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [2:0]        a_size,
    input  logic [SRC_W-1:0]  a_source,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              d_valid,
    input  logic              d_ready,
    input  logic [2:0]        d_opcode,
    input  logic [2:0]        d_size,
    input  logic [SRC_W-1:0]  d_source,
    input  logic              err_clear,
    output logic [SRC_W:0]    inflight_count,
    output logic [6:0]        err_flags,
    output logic              any_error
);

    localparam int              c_NSRC      = 1 << SRC_W;
    localparam int              c_TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [2:0]      c_BEAT_LOG2 = 3'(BEAT_BYTES_LOG2);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_SAT  = c_TO_W'(TIMEOUT);
    localparam logic [2:0]      c_PUT_FULL  = 3'd0;
    localparam logic [2:0]      c_PUT_PART  = 3'd1;
    localparam logic [2:0]      c_GET       = 3'd4;
    localparam logic [2:0]      c_ACK_DATA  = 3'd1;

    function automatic logic [7:0] f_beats(input logic [2:0] size);
        if (size <= c_BEAT_LOG2) return 8'd1;
        return 8'd1 << (size - c_BEAT_LOG2);
    endfunction

    // A-channel burst state (r_a_cnt == 0 means the next fire is a first beat)
    logic [7:0]        r_a_cnt, r_a_beats;
    logic [2:0]        r_a_op, r_a_size;
    logic [SRC_W-1:0]  r_a_src;
    logic [ADDR_W-1:0] r_a_addr;
    // D-channel burst state
    logic [7:0]        r_d_cnt, r_d_beats;
    logic [2:0]        r_d_op, r_d_size;
    logic [SRC_W-1:0]  r_d_src;
    logic              r_d_unexp;
    // Per-source table
    logic [c_NSRC-1:0]       r_pend;
    logic [c_NSRC-1:0]       r_exp_op;
    logic [c_NSRC-1:0][2:0]  r_size;

    logic [SRC_W:0]    r_count;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [6:0]        r_err;
    logic              r_any;

    logic              w_a_fire, w_d_fire;
    logic              w_a_first, w_a_mid, w_a_mid_last, w_a_legal, w_a_is_get;
    logic [7:0]        w_a_beats;
    logic              w_d_first, w_d_mid, w_d_mid_last, w_d_pend;
    logic [7:0]        w_d_beats;
    logic [c_NSRC-1:0] w_clr, w_set, w_pend_nxt;
    logic [SRC_W:0]    w_pend_cnt;
    logic              w_to_run, w_to_hit;
    logic [6:0]        w_new_err, w_err_nxt;

    assign w_a_fire     = a_valid & a_ready;
    assign w_d_fire     = d_valid & d_ready;

    assign w_a_first    = w_a_fire && (r_a_cnt == 8'd0);
    assign w_a_mid      = w_a_fire && (r_a_cnt != 8'd0);
    assign w_a_mid_last = w_a_mid && (r_a_cnt == r_a_beats - 8'd1);
    assign w_a_legal    = (a_opcode == c_PUT_FULL) || (a_opcode == c_PUT_PART) || (a_opcode == c_GET);
    assign w_a_is_get   = (a_opcode == c_GET);
    assign w_a_beats    = w_a_is_get ? 8'd1 : f_beats(a_size);

    assign w_d_first    = w_d_fire && (r_d_cnt == 8'd0);
    assign w_d_mid      = w_d_fire && (r_d_cnt != 8'd0);
    assign w_d_mid_last = w_d_mid && (r_d_cnt == r_d_beats - 8'd1);
    assign w_d_pend     = r_pend[d_source];
    assign w_d_beats    = (d_opcode == c_ACK_DATA) ? f_beats(d_size) : 8'd1;

    // Release from a completing D burst is applied before the A reuse check
    always_comb begin
        w_clr = '0;
        w_set = '0;
        if (w_d_first && (w_d_beats == 8'd1) && w_d_pend) w_clr[d_source] = 1'b1;
        if (w_d_mid_last && !r_d_unexp)                   w_clr[r_d_src]  = 1'b1;
        if (w_a_first && w_a_legal)                        w_set[a_source] = 1'b1;
    end

    assign w_pend_nxt = (r_pend & ~w_clr) | w_set;

    always_comb begin
        w_pend_cnt = '0;
        for (int i = 0; i < c_NSRC; i++) begin
            w_pend_cnt = w_pend_cnt + {{SRC_W{1'b0}}, w_pend_nxt[i]};
        end
    end

    assign w_to_run = (r_count != '0) && !w_d_fire;
    assign w_to_hit = w_to_run && (r_to_cnt == c_TO_LAST);

    assign w_new_err[0] = w_a_first && w_a_legal && r_pend[a_source] && !w_clr[a_source];
    assign w_new_err[1] = w_d_first && !w_d_pend;
    assign w_new_err[2] = w_d_first && w_d_pend && (d_opcode != {2'b00, r_exp_op[d_source]});
    assign w_new_err[3] = w_d_first && w_d_pend && (d_size != r_size[d_source]);
    assign w_new_err[4] = (w_a_first && !w_a_legal) ||
                          (w_a_mid && ((a_opcode != r_a_op) || (a_size != r_a_size) ||
                                       (a_source != r_a_src) || (a_address != r_a_addr)));
    assign w_new_err[5] = w_d_mid && ((d_opcode != r_d_op) || (d_size != r_d_size) ||
                                      (d_source != r_d_src));
    assign w_new_err[6] = w_to_hit;

    assign w_err_nxt = err_clear ? 7'd0 : (r_err | w_new_err);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a_cnt   <= '0;
            r_a_beats <= '0;
            r_a_op    <= '0;
            r_a_size  <= '0;
            r_a_src   <= '0;
            r_a_addr  <= '0;
        end else if (w_a_first && w_a_legal && (w_a_beats != 8'd1)) begin
            r_a_cnt   <= 8'd1;
            r_a_beats <= w_a_beats;
            r_a_op    <= a_opcode;
            r_a_size  <= a_size;
            r_a_src   <= a_source;
            r_a_addr  <= a_address;
        end else if (w_a_mid) begin
            r_a_cnt   <= w_a_mid_last ? 8'd0 : r_a_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_d_cnt   <= '0;
            r_d_beats <= '0;
            r_d_op    <= '0;
            r_d_size  <= '0;
            r_d_src   <= '0;
            r_d_unexp <= 1'b0;
        end else if (w_d_first && (w_d_beats != 8'd1)) begin
            r_d_cnt   <= 8'd1;
            r_d_beats <= w_d_beats;
            r_d_op    <= d_opcode;
            r_d_size  <= d_size;
            r_d_src   <= d_source;
            r_d_unexp <= !w_d_pend;
        end else if (w_d_mid) begin
            r_d_cnt   <= w_d_mid_last ? 8'd0 : r_d_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend   <= '0;
            r_exp_op <= '0;
            r_size   <= '0;
            r_count  <= '0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_count <= w_pend_cnt;
            if (w_a_first && w_a_legal) begin
                r_exp_op[a_source] <= w_a_is_get;
                r_size[a_source]   <= a_size;
            end
        end
    end

    // Saturating so a single stall window raises the timeout exactly once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (!w_to_run) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_TO_SAT) begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= '0;
            r_any <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
            r_any <= |w_err_nxt;
        end
    end

    assign inflight_count = r_count;
    assign err_flags      = r_err;
    assign any_error      = r_any;

endmodule
`default_nettype wire

// File: tb/tb_tl_inflight_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tl_inflight_tracker                                                      |
// | Scoreboard bench: directed scenarios plus random traffic vs reference model.|
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_tl_inflight_tracker;

    localparam int SRC_W  = 2;
    localparam int ADDR_W = 15;
    localparam int BBL    = 2;
    localparam int TMO    = 16;
    localparam int NSRC   = 1 << SRC_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              a_valid, a_ready, d_valid, d_ready, err_clear;
    logic [2:0]        a_opcode, a_size, d_opcode, d_size;
    logic [SRC_W-1:0]  a_source, d_source;
    logic [ADDR_W-1:0] a_address;
    logic [SRC_W:0]    inflight_count;
    logic [6:0]        err_flags;
    logic              any_error;

    always #5 clock = ~clock;

    tl_inflight_tracker #(
        .SRC_W(SRC_W), .ADDR_W(ADDR_W), .BEAT_BYTES_LOG2(BBL), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
        .d_source(d_source), .err_clear(err_clear),
        .inflight_count(inflight_count), .err_flags(err_flags), .any_error(any_error)
    );

    typedef struct packed {
        logic [SRC_W:0] cnt;
        logic [6:0]     flags;
        logic           any;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: transaction-level view of the link
    int m_pend[NSRC], m_exp[NSRC], m_size[NSRC];
    int m_a_left, m_a_op, m_a_sz, m_a_src, m_a_addr;
    int m_d_left, m_d_op, m_d_sz, m_d_src, m_d_bad;
    int m_idle, m_flags;

    function automatic int beats(int sz);
        return (sz <= BBL) ? 1 : (1 << (sz - BBL));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) begin
            m_pend[i] = 0; m_exp[i] = 0; m_size[i] = 0;
        end
        m_a_left = 0; m_a_op = 0; m_a_sz = 0; m_a_src = 0; m_a_addr = 0;
        m_d_left = 0; m_d_op = 0; m_d_sz = 0; m_d_src = 0; m_d_bad = 0;
        m_idle = 0; m_flags = 0;
    endtask

    task automatic model_step();
        int rel, set, nb, nw, old_cnt, ao, asz, asrc, aadr, dop, dsz, dsrc;
        bit dfire;
        rel = -1; set = -1; nw = 0; old_cnt = 0;
        for (int i = 0; i < NSRC; i++) old_cnt += m_pend[i];
        ao = int'(a_opcode); asz = int'(a_size); asrc = int'(a_source); aadr = int'(a_address);
        dop = int'(d_opcode); dsz = int'(d_size); dsrc = int'(d_source);
        dfire = d_valid && d_ready;
        if (dfire) begin
            if (m_d_left == 0) begin
                nb = (dop == 1) ? beats(dsz) : 1;
                if (m_pend[dsrc] == 0) nw |= 2;
                else begin
                    if (dop != m_exp[dsrc])  nw |= 4;
                    if (dsz != m_size[dsrc]) nw |= 8;
                end
                if (nb == 1) begin
                    if (m_pend[dsrc] != 0) rel = dsrc;
                end else begin
                    m_d_left = nb - 1; m_d_op = dop; m_d_sz = dsz; m_d_src = dsrc;
                    m_d_bad = (m_pend[dsrc] == 0) ? 1 : 0;
                end
            end else begin
                if (dop != m_d_op || dsz != m_d_sz || dsrc != m_d_src) nw |= 32;
                m_d_left--;
                if (m_d_left == 0 && m_d_bad == 0) rel = m_d_src;
            end
        end
        if (a_valid && a_ready) begin
            if (m_a_left == 0) begin
                if (ao != 0 && ao != 1 && ao != 4) nw |= 16;
                else begin
                    if (m_pend[asrc] != 0 && rel != asrc) nw |= 1;
                    set = asrc;
                    m_exp[asrc]  = (ao == 4) ? 1 : 0;
                    m_size[asrc] = asz;
                    nb = (ao == 4) ? 1 : beats(asz);
                    if (nb > 1) begin
                        m_a_left = nb - 1; m_a_op = ao; m_a_sz = asz; m_a_src = asrc; m_a_addr = aadr;
                    end
                end
            end else begin
                if (ao != m_a_op || asz != m_a_sz || asrc != m_a_src || aadr != m_a_addr) nw |= 16;
                m_a_left--;
            end
        end
        if (old_cnt != 0 && !dfire) begin
            if (m_idle == TMO - 1) nw |= 64;
            m_idle++;
        end else begin
            m_idle = 0;
        end
        if (rel >= 0) m_pend[rel] = 0;
        if (set >= 0) m_pend[set] = 1;
        m_flags = err_clear ? 0 : (m_flags | nw);
    endtask

    task automatic tick();
        exp_t e;
        int c;
        if (reset) model_reset();
        else model_step();
        c = 0;
        for (int i = 0; i < NSRC; i++) c += m_pend[i];
        e.cnt   = (SRC_W+1)'(c);
        e.flags = 7'(m_flags);
        e.any   = (m_flags != 0);
        q.push_back(e);
        @(negedge clock);
    endtask

    // Monitor: one expectation per rising edge, compared just after it
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (inflight_count !== e.cnt || err_flags !== e.flags || any_error !== e.any) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got cnt=%0d flags=%b any=%b, expected cnt=%0d flags=%b any=%b",
                             $time, inflight_count, err_flags, any_error, e.cnt, e.flags, e.any);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got time=%0t expected < 400000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic set_idle();
        a_valid = 0; a_ready = 0; d_valid = 0; d_ready = 0; err_clear = 0;
    endtask

    task automatic idle(int n);
        set_idle();
        repeat (n) tick();
    endtask

    task automatic a_cyc(int op, int sz, int src, int addr);
        set_idle();
        a_valid = 1; a_ready = 1;
        a_opcode = 3'(op); a_size = 3'(sz); a_source = SRC_W'(src); a_address = ADDR_W'(addr);
        tick();
    endtask

    task automatic d_cyc(int op, int sz, int src);
        set_idle();
        d_valid = 1; d_ready = 1;
        d_opcode = 3'(op); d_size = 3'(sz); d_source = SRC_W'(src);
        tick();
    endtask

    task automatic ad_cyc(int aop, int asz, int asrc, int dop, int dsz, int dsrc);
        set_idle();
        a_valid = 1; a_ready = 1;
        a_opcode = 3'(aop); a_size = 3'(asz); a_source = SRC_W'(asrc); a_address = '0;
        d_valid = 1; d_ready = 1;
        d_opcode = 3'(dop); d_size = 3'(dsz); d_source = SRC_W'(dsrc);
        tick();
    endtask

    task automatic clr();
        set_idle();
        err_clear = 1;
        tick();
    endtask

    task automatic rand_cycle();
        int r, s, st, found;
        a_valid = ($urandom_range(0, 2) != 0);
        a_ready = ($urandom_range(0, 3) != 0);
        if (m_a_left > 0) begin
            a_opcode = 3'(m_a_op); a_size = 3'(m_a_sz);
            a_source = SRC_W'(m_a_src); a_address = ADDR_W'(m_a_addr);
            if ($urandom_range(0, 39) == 0) a_address = a_address ^ ADDR_W'(1);
        end else begin
            r = $urandom_range(0, 19);
            a_opcode = (r < 7) ? 3'd0 : (r < 12) ? 3'd1 : (r < 19) ? 3'd4 : 3'd5;
            a_size = 3'($urandom_range(0, 4));
            s = $urandom_range(0, NSRC - 1);
            if (m_pend[s] != 0 && $urandom_range(0, 4) != 0) s = $urandom_range(0, NSRC - 1);
            a_source = SRC_W'(s);
            a_address = ADDR_W'($urandom);
        end
        d_ready = ($urandom_range(0, 3) != 0);
        if (m_d_left > 0) begin
            d_valid = ($urandom_range(0, 1) != 0);
            d_opcode = 3'(m_d_op); d_size = 3'(m_d_sz); d_source = SRC_W'(m_d_src);
            if ($urandom_range(0, 39) == 0) d_size = d_size ^ 3'd1;
        end else begin
            st = $urandom_range(0, NSRC - 1);
            found = -1;
            for (int i = 0; i < NSRC; i++)
                if (found < 0 && m_pend[(st + i) % NSRC] != 0) found = (st + i) % NSRC;
            if (found >= 0) begin
                d_valid = ($urandom_range(0, 2) == 0);
                d_source = SRC_W'(found);
                d_opcode = 3'(m_exp[found]);
                d_size = 3'(m_size[found]);
                if ($urandom_range(0, 29) == 0) d_opcode = d_opcode ^ 3'd1;
            end else begin
                d_valid = ($urandom_range(0, 29) == 0);
                d_source = SRC_W'($urandom_range(0, NSRC - 1));
                d_opcode = 3'($urandom_range(0, 1));
                d_size = 3'($urandom_range(0, 3));
            end
        end
        err_clear = ($urandom_range(0, 39) == 0);
        tick();
    endtask

    initial begin
        model_reset();
        reset = 1;
        set_idle();
        a_opcode = '0; a_size = '0; a_source = '0; a_address = '0;
        d_opcode = '0; d_size = '0; d_source = '0;
        tick(); tick(); tick();
        reset = 0;

        // Get/AccessAckData round trip
        a_cyc(4, 2, 1, 16'h40);
        idle(2);
        d_cyc(1, 2, 1);
        idle(2);

        // 4-beat PutFull, clean then with source changed on beat 2
        for (int b = 0; b < 4; b++) a_cyc(0, 4, 0, 16'h100);
        d_cyc(0, 4, 0);
        a_cyc(0, 4, 0, 16'h200);
        a_cyc(0, 4, 1, 16'h200);
        a_cyc(0, 4, 0, 16'h200);
        a_cyc(0, 4, 0, 16'h200);
        d_cyc(0, 4, 0);
        clr();

        // Source reuse, then same-cycle release and reuse
        a_cyc(4, 2, 2, 0);
        a_cyc(4, 2, 2, 0);
        clr();
        ad_cyc(4, 2, 2, 1, 2, 2);
        d_cyc(1, 2, 2);
        idle(1);

        // Unexpected D, opcode mismatch, size mismatch (2-beat data)
        d_cyc(0, 2, 3);
        clr();
        a_cyc(4, 2, 0, 0);
        d_cyc(0, 2, 0);
        clr();
        a_cyc(4, 2, 1, 0);
        d_cyc(1, 3, 1);
        d_cyc(1, 3, 1);
        clr();

        // Watchdog
        a_cyc(4, 2, 0, 0);
        idle(18);
        clr();
        d_cyc(1, 2, 0);
        idle(2);

        // Asynchronous reset in the middle of a 4-beat Put
        a_cyc(0, 4, 0, 16'h300);
        a_cyc(0, 4, 0, 16'h300);
        set_idle();
        reset = 1;
        #1;
        checks++;
        if (inflight_count !== '0 || err_flags !== '0 || any_error !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got cnt=%0d flags=%b any=%b, expected all zero",
                     inflight_count, err_flags, any_error);
        end
        tick();
        reset = 0;
        a_cyc(4, 0, 3, 0);
        d_cyc(1, 0, 3);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) rand_cycle();
        idle(3);

        @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tl_inflight_tracker.md
Name: tl_inflight_tracker

Overview:
Passive TileLink-UL checker placed on the same A/D link that feeds the TL protocol monitor.
- Keeps a per-source table of outstanding requests.
- Checks each D response against its A request: source pending, opcode pairing, size.
- Tracks burst beats on both channels.
- Provides a liveness watchdog.
- Raises sticky error flags for the simulation bench. It never drives the link.

Parameters:
SRC_W, 2, source-ID width; table has 2^SRC_W entries
ADDR_W, 15, A-channel address width
BEAT_BYTES_LOG2, 2, log2 of data-bus bytes per beat
TIMEOUT, 1024, cycles with outstanding requests and no D fire before timeout error

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-high reset
a_valid  input  1  A channel valid
a_ready  input  1  A channel ready
a_opcode  input  3  0=PutFull, 1=PutPartial, 4=Get
a_size  input  3  log2 transfer bytes
a_source  input  SRC_W  A source ID
a_address  input  ADDR_W  A address
d_valid  input  1  D channel valid
d_ready  input  1  D channel ready
d_opcode  input  3  0=AccessAck, 1=AccessAckData
d_size  input  3  log2 transfer bytes
d_source  input  SRC_W  D source ID
err_clear  input  1  synchronous clear of sticky errors
inflight_count  output  SRC_W+1  number of pending sources
err_flags  output  7  sticky error bits, see Behaviour
any_error  output  1  OR of err_flags

Behaviour:
Fire and beat counting
- a_fire = a_valid & a_ready; d_fire = d_valid & d_ready. Only fires are sampled.
- beats(size) = 1 if size <= BEAT_BYTES_LOG2, else 2^(size-BEAT_BYTES_LOG2).
- A bursts: Puts only, beats(a_size) beats. Gets are always 1 A beat.
- D bursts: AccessAckData has beats(d_size) beats. AccessAck is 1 beat.
- Beat counters a_cnt and d_cnt are independent. Each resets to 0 after the last beat.

Table and register updates
- Table entry per source: pending, exp_opcode (Put→0, Get→1), size.
- A first beat: writes the entry and sets pending.
- D last beat: clears pending.
- Same cycle, same source, D last beat and A first beat: release is applied before the A check. No reuse error; the entry is rewritten with pending=1.
- All state and outputs are registered. A flag becomes visible the cycle after the offending fire.
- inflight_count updates the cycle after the fire; simultaneous set and clear of different sources leave it unchanged.

err_flags (sticky until err_clear; err_clear wins over a same-cycle new error)
- bit0 src_reuse: A first beat to a source still pending.
- bit1 d_unexpected: D first beat to a non-pending source.
- bit2 d_opcode: d_opcode != exp_opcode.
- bit3 d_size: d_size != stored size.
- bit4 a_burst: a_opcode, a_size, a_source or a_address changed mid A burst vs the first beat.
- bit5 d_burst: d_opcode, d_size or d_source changed mid D burst.
- bit6 timeout: counter increments while inflight_count != 0 and no d_fire; cleared on d_fire or when count reaches 0; flag sets when counter == TIMEOUT-1.

Error side effects
- On d_unexpected, the table is not modified and the beat counter still advances.
- Illegal a_opcode (not 0/1/4) sets a_burst and is not recorded.
- An error never blocks table updates.

Reset
- Table pending bits, counters, inflight_count, err_flags and any_error are 0 asynchronously.
- Reset mid-burst discards all partial bursts.

Test Plan:
- Get src=1 size=2, then AccessAckData src=1 size=2 three cycles later -> inflight_count 1 then 0, err_flags=0.
- PutFull src=0 size=4 (4 beats, beat=4B), then AccessAck size=4 -> a_cnt wraps after beat 4, no errors; a_source changed on beat 2 -> err_flags[4]=1 next cycle.
- Get src=2, second Get src=2 before response -> err_flags[0]=1; same-cycle D last beat src=2 plus A Get src=2 -> no error, count stays 1.
- AccessAck src=3 with nothing pending -> err_flags[1]=1; Get src=0 answered with AccessAck -> err_flags[2]=1; d_size 3 vs 2 -> err_flags[3]=1.
- TIMEOUT=16, Get pending, no D for 16 cycles -> err_flags[6]=1 in cycle 16; err_clear -> err_flags=0 next cycle.
- Assert reset during a 4-beat Put after beat 2 -> all outputs 0 immediately; new 1-beat Get after reset tracked with no errors.
